// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory read channel, the decode-side slot handshake
// and the EX redirect that the fetch stage exchanges with the rest of the core.
interface fetch_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata,
    input  id_ready,
    input  redirect,
    input  redirect_pc,
    output if_valid,
    output if_ir,
    output if_pc
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata,
    output id_ready,
    output redirect,
    output redirect_pc,
    input  if_valid,
    input  if_ir,
    input  if_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, blocking imem read handshake,
// IF/ID output slot, and redirect handling including redirects during a read.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        read_q, read_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_ir_q, if_ir_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic [31:0] redirect_target;
  logic        slot_free;

  assign redirect_target = bus.redirect_pc & ~32'h3;
  assign slot_free       = !if_valid_q || bus.id_ready || bus.redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = if_valid_q;
    if_ir_d    = if_ir_q;
    if_pc_d    = if_pc_q;

    // Decode consumes the slot, or a redirect squashes whatever it holds.
    if ((if_valid_q && bus.id_ready) || bus.redirect) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      HOLD: begin
        if (bus.redirect) begin
          pc_d    = redirect_target;
          state_d = FETCH;
        end else if (slot_free) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (bus.imem_resp && !bus.redirect) begin
          if_ir_d    = bus.imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = HOLD;
        end else if (bus.imem_resp) begin
          pc_d = redirect_target;
        end else if (bus.redirect) begin
          // Address must stay stable until memory answers, so park the target.
          pend_pc_d = redirect_target;
          state_d   = DROP;
        end
      end

      DROP: begin
        if (bus.imem_resp) begin
          pc_d    = bus.redirect ? redirect_target : pend_pc_q;
          state_d = FETCH;
        end else if (bus.redirect) begin
          pend_pc_d = redirect_target;
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    read_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      read_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_ir_q    <= NOP;
      if_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      read_q     <= read_d;
      if_valid_q <= if_valid_d;
      if_ir_q    <= if_ir_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign bus.imem_read    = read_q;
  assign bus.imem_address = pc_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_ir        = if_ir_q;
  assign bus.if_pc        = if_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// redirect/reset/wrap sequences, then randomized traffic against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] R   = 32'h6000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        idr;
    logic        redir;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic idr, logic rd, logic [31:0] rpc, logic rs,
                              logic [31:0] rdat, logic er, logic [31:0] ea,
                              logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.idr = idr; v.redir = rd; v.rpc = rpc; v.resp = rs; v.rdata = rdat;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_ir = ei; v.e_pc = ep;
    return v;
  endfunction

  // Memory contents used during random traffic: a fixed scramble of the address.
  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_bus(string tag, logic er, logic [31:0] ea, logic ev);
    chk32({tag, ".imem_read"}, {31'b0, bus.imem_read}, {31'b0, er});
    chk32({tag, ".imem_address"}, bus.imem_address, ea);
    chk32({tag, ".if_valid"}, {31'b0, bus.if_valid}, {31'b0, ev});
  endtask

  task automatic chk_slot(string tag, logic [31:0] ei, logic [31:0] ep);
    chk32({tag, ".if_ir"}, bus.if_ir, ei);
    chk32({tag, ".if_pc"}, bus.if_pc, ep);
  endtask

  // Apply inputs for one cycle, starting and ending on a falling edge.
  task automatic drive(logic idr, logic rd, logic [31:0] rpc, logic rs, logic [31:0] rdat);
    bus.id_ready    = idr;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_resp   = rs;
    bus.imem_rdata  = rdat;
    @(negedge clk);
    bus.redirect  = 1'b0;
    bus.imem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_resp = 1'b0; bus.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-phase state
  logic [31:0] exp_next;
  int          delivered;
  int          mem_cnt;
  int          mem_lat;
  logic        prev_read, prev_resp, prev_valid, prev_taken, prev_redir;
  logic [31:0] prev_addr, prev_ir, prev_pc;
  logic        r_idr, r_redir;
  logic [31:0] r_rpc;

  initial begin
    rst_n = 1'b0;
    vecs[0]  = mk(1, 0, 0,              0, 0,            0, R,              0, NOP,          32'h0);
    vecs[1]  = mk(1, 0, 0,              0, 0,            1, R,              0, NOP,          32'h0);
    vecs[2]  = mk(1, 0, 0,              1, 32'h00500093, 1, R,              0, NOP,          32'h0);
    vecs[3]  = mk(0, 0, 0,              0, 0,            0, R + 4,          1, 32'h00500093, R);
    vecs[4]  = mk(0, 0, 0,              0, 0,            0, R + 4,          1, 32'h00500093, R);
    vecs[5]  = mk(0, 0, 0,              0, 0,            0, R + 4,          1, 32'h00500093, R);
    vecs[6]  = mk(0, 0, 0,              0, 0,            0, R + 4,          1, 32'h00500093, R);
    vecs[7]  = mk(0, 0, 0,              0, 0,            0, R + 4,          1, 32'h00500093, R);
    vecs[8]  = mk(1, 0, 0,              0, 0,            0, R + 4,          1, 32'h00500093, R);
    vecs[9]  = mk(1, 0, 0,              0, 0,            1, R + 4,          0, 32'h00500093, R);
    vecs[10] = mk(0, 0, 0,              1, 32'h00A00113, 1, R + 4,          0, 32'h00500093, R);
    vecs[11] = mk(0, 1, 32'h6000_0102,  0, 0,            0, R + 8,          1, 32'h00A00113, R + 4);
    vecs[12] = mk(0, 0, 0,              0, 0,            1, 32'h6000_0100,  0, 32'h00A00113, R + 4);
    vecs[13] = mk(0, 0, 0,              1, 32'h12345678, 1, 32'h6000_0100,  0, 32'h00A00113, R + 4);
    vecs[14] = mk(0, 0, 0,              0, 0,            0, 32'h6000_0104,  1, 32'h12345678, 32'h6000_0100);

    do_reset();

    // Tests 1-3: cycle-by-cycle table (outputs checked, then inputs applied).
    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      chk_bus(tag, vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid);
      chk_slot(tag, vecs[i].e_ir, vecs[i].e_pc);
      drive(vecs[i].idr, vecs[i].redir, vecs[i].rpc, vecs[i].resp, vecs[i].rdata);
    end
    $display("table: %0d vectors applied", 15);

    // Test 4: redirect during a latency-4 read; stale word must not reach the slot.
    drive(1, 0, 0, 0, 0);
    chk_bus("t4.fetch", 1, 32'h6000_0104, 0);
    drive(1, 1, 32'h6000_0200, 0, 0);
    chk_bus("t4.drop0", 1, 32'h6000_0104, 0);
    drive(1, 0, 0, 0, 0);
    chk_bus("t4.drop1", 1, 32'h6000_0104, 0);
    drive(1, 0, 0, 0, 0);
    chk_bus("t4.drop2", 1, 32'h6000_0104, 0);
    drive(1, 0, 0, 1, 32'hBAD0_BAD0);
    chk_bus("t4.refetch", 1, 32'h6000_0200, 0);
    $display("t4: redirect during outstanding read to 60000200");

    // Test 5: two redirects in DROP, the second coinciding with the response.
    drive(1, 1, 32'h6000_0300, 0, 0);
    chk_bus("t5.drop0", 1, 32'h6000_0200, 0);
    drive(1, 0, 0, 0, 0);
    chk_bus("t5.drop1", 1, 32'h6000_0200, 0);
    drive(1, 1, 32'h6000_0400, 1, 32'hDEAD_DEAD);
    chk_bus("t5.refetch", 1, 32'h6000_0400, 0);
    drive(0, 0, 0, 1, 32'h00C0_0193);
    chk_bus("t5.fill", 0, 32'h6000_0404, 1);
    chk_slot("t5.fill", 32'h00C0_0193, 32'h6000_0400);
    $display("t5: latest redirect wins, slot pc=%08h", bus.if_pc);

    // PC wrap at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFE, 0, 0);
    chk_bus("wrap.fetch", 1, 32'hFFFF_FFFC, 0);
    drive(0, 0, 0, 1, 32'h0010_0073);
    chk_bus("wrap.fill", 0, 32'h0000_0000, 1);
    chk_slot("wrap.fill", 32'h0010_0073, 32'hFFFF_FFFC);
    $display("wrap: slot pc=%08h next addr=%08h", bus.if_pc, bus.imem_address);

    // Test 6: asynchronous reset in the middle of a read.
    drive(1, 0, 0, 0, 0);
    chk_bus("t6.fetch", 1, 32'h0000_0000, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_bus("t6.async", 0, R, 0);
    chk_slot("t6.async", NOP, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    chk_bus("t6.released", 0, R, 0);
    drive(1, 0, 0, 0, 0);
    chk_bus("t6.restart", 1, R, 0);
    $display("t6: async reset, refetch from %08h", bus.imem_address);

    // Randomized traffic against a program-order model.
    do_reset();
    exp_next  = R;
    delivered = 0;
    mem_cnt   = 0;
    mem_lat   = 1;
    prev_read = 0; prev_resp = 0; prev_valid = 0; prev_taken = 0; prev_redir = 0;
    prev_addr = 0; prev_ir = 0; prev_pc = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      // A read in flight without a response must persist at the same address.
      if (prev_read && !prev_resp) begin
        chk32("rnd.read_held", {31'b0, bus.imem_read}, 32'h1);
        chk32("rnd.addr_stable", bus.imem_address, prev_addr);
      end
      // An unconsumed, unsquashed slot must not change.
      if (prev_valid && !prev_taken && !prev_redir) begin
        chk32("rnd.slot_valid", {31'b0, bus.if_valid}, 32'h1);
        chk32("rnd.slot_ir", bus.if_ir, prev_ir);
        chk32("rnd.slot_pc", bus.if_pc, prev_pc);
      end

      // Memory: answer after mem_lat cycles of continuous request.
      prev_resp = bus.imem_resp;
      if (bus.imem_resp) begin
        bus.imem_resp = 1'b0;
        mem_cnt = 0;
      end
      if (bus.imem_read) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = memf(bus.imem_address);
          mem_cnt = 0;
          mem_lat = $urandom_range(1, 4);
        end
      end else begin
        mem_cnt = 0;
      end
      prev_resp = bus.imem_resp;

      r_idr   = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       r_rpc = R + {$urandom_range(0, 255), 2'b0} + 32'($urandom_range(0, 3));
        1:       r_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: r_rpc = $urandom;
      endcase
      bus.id_ready    = r_idr;
      bus.redirect    = r_redir;
      bus.redirect_pc = r_rpc;

      if (r_redir) begin
        exp_next = r_rpc & ~32'h3;
      end else if (bus.if_valid && r_idr) begin
        chk32("rnd.order_pc", bus.if_pc, exp_next);
        chk32("rnd.word", bus.if_ir, memf(bus.if_pc));
        exp_next = exp_next + 32'd4;
        delivered++;
      end

      prev_read  = bus.imem_read;
      prev_addr  = bus.imem_address;
      prev_valid = bus.if_valid;
      prev_ir    = bus.if_ir;
      prev_pc    = bus.if_pc;
      prev_taken = r_idr;
      prev_redir = r_redir;
      @(negedge clk);
    end
    bus.redirect = 1'b0;
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL rnd.throughput: got %0d delivered expected at least 200", delivered);
    end
    $display("random: %0d instructions delivered in order", delivered);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline.
- Holds the PC and runs a blocking read handshake with instruction memory.
- Registers the fetched word and its PC into the IF/ID output slot, where decode and the immediate generator consume it.
- Handles decode backpressure and branch/jump redirects, including redirects that arrive while a memory read is still outstanding.

Parameters:
- RESET_PC, 32'h6000_0000, PC value loaded on reset (low 2 bits must be 0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_read  output  1  instruction read request; held high until imem_resp.
- imem_address  output  32  read address; stable while imem_read is high.
- imem_resp  input  1  one-cycle pulse: imem_rdata valid, request complete.
- imem_rdata  input  32  instruction word.
- id_ready  input  1  decode accepts the output slot this cycle.
- redirect  input  1  branch/jump taken, from EX; one-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] are forced to 0 internally.
- if_valid  output  1  output slot holds a valid instruction.
- if_ir  output  32  instruction word (ir) for decode.
- if_pc  output  32  PC of if_ir.

Behaviour:
- Reset (async, rst_n=0):
  - state=HOLD, pc=RESET_PC, pend_pc=0.
  - if_valid=0, if_ir=32'h0000_0013 (nop), if_pc=0.
  - imem_read=0, imem_address=RESET_PC.
  - A reset deasserted mid-read abandons that read; memory must tolerate an abandoned request.
- Outputs:
  - imem_read=1 exactly in FETCH or DROP.
  - imem_address=pc at all times.
  - if_* come directly from registers, with no combinational path from inputs.
- Slot transfer: occurs on a cycle with if_valid=1 and id_ready=1. With no new fill that cycle, if_valid clears next cycle.
- Slot free condition: free = !if_valid | id_ready | redirect.
- Invariant: if_valid=0 throughout FETCH. The slot is filled only by a FETCH response.
- HOLD:
  - redirect → pc<=redirect_pc&~3, if_valid<=0, go FETCH.
  - else if free → go FETCH.
  - else stay in HOLD.
- FETCH:
  - imem_resp & !redirect → if_ir<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (wraps mod 2^32), go HOLD.
  - imem_resp & redirect → discard rdata, pc<=redirect_pc&~3, go FETCH.
  - !imem_resp & redirect → pend_pc<=redirect_pc&~3, go DROP. pc is unchanged so the address stays stable.
  - else stay in FETCH.
- DROP:
  - Keep the request asserted at the old pc.
  - redirect → pend_pc<=redirect_pc&~3 (latest redirect wins).
  - imem_resp → discard rdata, pc<=pend_pc, or the new redirect target if one arrives the same cycle. Go FETCH.
- Redirect in any state clears if_valid next cycle. Redirect has priority over id_ready, so decode must squash on redirect.
- Throughput: at most 1 instruction per 2 cycles with single-cycle memory (FETCH→HOLD→FETCH).
- Latency: from entering FETCH, if_valid rises the cycle after imem_resp.

Test Plan:
1. Reset release, memory answers 1 cycle after each request with rdata=0x00500093 then 0x00A00113, id_ready=1 → first request at 0x60000000. Slot shows (ir=0x00500093, pc=0x60000000), then (0x00A00113, 0x60000004). imem_read never high in HOLD.
2. Hold id_ready=0 for 5 cycles after the first fill → if_valid, if_ir and if_pc stay constant and imem_read=0. After id_ready=1, the next request goes to 0x60000004 with no instruction lost or duplicated.
3. Redirect to 0x60000102 while in HOLD with the slot full → if_valid=0 next cycle. The next request goes to 0x60000100 (bits [1:0] cleared).
4. Redirect to 0x60000200 in FETCH with memory latency 4 → imem_read stays high at the old address until imem_resp, and that rdata never appears on if_ir. The next request goes to 0x60000200.
5. Two redirects (0x60000300, then 0x60000400) during DROP, with the second coinciding with imem_resp → the next fetch address is 0x60000400.
6. Assert rst_n=0 mid-FETCH → outputs go to reset values immediately, without waiting for a clock edge. After release, fetching restarts at RESET_PC. Also cover pc=0xFFFFFFFC, which wraps to 0x00000000.
